// File: rtl/id_stage_pipe.sv
// Decode stage with a valid/ready ID/EX output register and combinational register-file reads.
// Define ID_LONG_IMM_EN to enable the two-word LIMM (load 16-bit immediate) instruction.
module id_stage_pipe #(
  parameter int unsigned WORD_LEN          = 16,
  parameter int unsigned REG_FILE_ADDR_LEN = 4,
  parameter int unsigned EXE_CMD_LEN       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  instruction,
  output logic [REG_FILE_ADDR_LEN-1:0] src1,
  output logic [REG_FILE_ADDR_LEN-1:0] src2_reg_file,
  input  logic [WORD_LEN-1:0]          reg1,
  input  logic [WORD_LEN-1:0]          reg2,
  input  logic                         hazard_detected_in,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_LEN-1:0]          val1,
  output logic [WORD_LEN-1:0]          val2,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic [EXE_CMD_LEN-1:0]       EXE_CMD,
  output logic                         MEM_R_EN,
  output logic                         MEM_W_EN,
  output logic                         WB_EN,
  output logic                         is_imm,
  output logic                         brTaken,
  output logic                         jumpEnable,
  output logic [WORD_LEN-1:0]          br_offset
);

  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpXor  = 4'h5;
  localparam logic [3:0] OpSll  = 4'h6;
  localparam logic [3:0] OpAddi = 4'h7;
  localparam logic [3:0] OpLd   = 4'h8;
  localparam logic [3:0] OpSt   = 4'h9;
  localparam logic [3:0] OpBeq  = 4'hA;
  localparam logic [3:0] OpBne  = 4'hB;
  localparam logic [3:0] OpJmp  = 4'hC;

  localparam logic [EXE_CMD_LEN-1:0] CmdAdd = EXE_CMD_LEN'(1);
  localparam logic [EXE_CMD_LEN-1:0] CmdSub = EXE_CMD_LEN'(2);
  localparam logic [EXE_CMD_LEN-1:0] CmdAnd = EXE_CMD_LEN'(3);
  localparam logic [EXE_CMD_LEN-1:0] CmdOr  = EXE_CMD_LEN'(4);
  localparam logic [EXE_CMD_LEN-1:0] CmdXor = EXE_CMD_LEN'(5);
  localparam logic [EXE_CMD_LEN-1:0] CmdSll = EXE_CMD_LEN'(6);

`ifdef ID_LONG_IMM_EN
  localparam logic [3:0] OpLimm = 4'hD;
  typedef enum logic [0:0] {StIdle, StWaitExt} state_e;
  state_e                       r_state;
  logic [REG_FILE_ADDR_LEN-1:0] r_ext_dest;
`endif

  logic [3:0]                   w_op;
  logic [WORD_LEN-1:0]          w_simm, w_zimm;
  logic                         w_xfer, w_load;
  logic [WORD_LEN-1:0]          w_val1, w_val2, w_off;
  logic [REG_FILE_ADDR_LEN-1:0] w_dest;
  logic [EXE_CMD_LEN-1:0]       w_cmd;
  logic                         w_mr, w_mw, w_wb, w_imm, w_br, w_jmp;

  logic                         r_out_valid;
  logic [WORD_LEN-1:0]          r_val1, r_val2, r_off;
  logic [REG_FILE_ADDR_LEN-1:0] r_dest;
  logic [EXE_CMD_LEN-1:0]       r_cmd;
  logic                         r_mr, r_mw, r_wb, r_imm, r_br, r_jmp;

  assign w_op   = instruction[15:12];
  assign w_simm = WORD_LEN'($signed(instruction[7:0]));
  assign w_zimm = WORD_LEN'(instruction[7:0]);

  // Stores and branches read their second operand from the rd field.
  assign src1          = REG_FILE_ADDR_LEN'(instruction[11:8]);
  assign src2_reg_file = (w_op == OpSt || w_op == OpBeq || w_op == OpBne) ?
                         REG_FILE_ADDR_LEN'(instruction[11:8]) :
                         REG_FILE_ADDR_LEN'(instruction[7:4]);

  assign in_ready = rst && !hazard_detected_in && !flush && (!r_out_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;

  always_comb begin
    w_load = 1'b1;
    w_val1 = reg1;
    w_val2 = reg2;
    w_dest = REG_FILE_ADDR_LEN'(instruction[11:8]);
    w_cmd  = '0;
    w_mr   = 1'b0;
    w_mw   = 1'b0;
    w_wb   = 1'b0;
    w_imm  = 1'b0;
    w_br   = 1'b0;
    w_jmp  = 1'b0;
    w_off  = w_simm;
`ifdef ID_LONG_IMM_EN
    // Second LIMM word is raw immediate data, not an instruction.
    if (r_state == StWaitExt) begin
      w_val1 = '0;
      w_val2 = WORD_LEN'(instruction);
      w_dest = r_ext_dest;
      w_cmd  = CmdAdd;
      w_wb   = 1'b1;
      w_imm  = 1'b1;
      w_off  = '0;
    end else
`endif
    begin
      case (w_op)
        OpAdd:  begin w_cmd = CmdAdd; w_wb = 1'b1; end
        OpSub:  begin w_cmd = CmdSub; w_wb = 1'b1; end
        OpAnd:  begin w_cmd = CmdAnd; w_wb = 1'b1; end
        OpOr:   begin w_cmd = CmdOr;  w_wb = 1'b1; end
        OpXor:  begin w_cmd = CmdXor; w_wb = 1'b1; end
        OpSll:  begin w_cmd = CmdSll; w_wb = 1'b1; w_imm = 1'b1; w_val2 = w_zimm; end
        OpAddi: begin w_cmd = CmdAdd; w_wb = 1'b1; w_imm = 1'b1; w_val2 = w_simm; end
        OpLd:   begin
          w_cmd = CmdAdd; w_wb = 1'b1; w_mr = 1'b1; w_imm = 1'b1; w_val2 = w_simm;
        end
        OpSt:   begin w_cmd = CmdAdd; w_mw = 1'b1; w_imm = 1'b1; w_val2 = w_simm; end
        OpBeq:  w_br  = (reg1 == reg2);
        OpBne:  w_br  = (reg1 != reg2);
        OpJmp:  w_jmp = 1'b1;
`ifdef ID_LONG_IMM_EN
        OpLimm: w_load = 1'b0;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_val1      <= '0;
      r_val2      <= '0;
      r_dest      <= '0;
      r_cmd       <= '0;
      r_mr        <= 1'b0;
      r_mw        <= 1'b0;
      r_wb        <= 1'b0;
      r_imm       <= 1'b0;
      r_br        <= 1'b0;
      r_jmp       <= 1'b0;
      r_off       <= '0;
`ifdef ID_LONG_IMM_EN
      r_state     <= StIdle;
      r_ext_dest  <= '0;
`endif
    end else if (flush) begin
      r_out_valid <= 1'b0;
`ifdef ID_LONG_IMM_EN
      r_state     <= StIdle;
`endif
    end else if (w_xfer) begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_val1 <= w_val1;
        r_val2 <= w_val2;
        r_dest <= w_dest;
        r_cmd  <= w_cmd;
        r_mr   <= w_mr;
        r_mw   <= w_mw;
        r_wb   <= w_wb;
        r_imm  <= w_imm;
        r_br   <= w_br;
        r_jmp  <= w_jmp;
        r_off  <= w_off;
      end
`ifdef ID_LONG_IMM_EN
      if (r_state == StWaitExt) begin
        r_state <= StIdle;
      end else if (w_op == OpLimm) begin
        r_state    <= StWaitExt;
        r_ext_dest <= REG_FILE_ADDR_LEN'(instruction[11:8]);
      end
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign val1       = r_val1;
  assign val2       = r_val2;
  assign dest       = r_dest;
  assign EXE_CMD    = r_cmd;
  assign MEM_R_EN   = r_mr;
  assign MEM_W_EN   = r_mw;
  assign WB_EN      = r_wb;
  assign is_imm     = r_imm;
  assign brTaken    = r_br;
  assign jumpEnable = r_jmp;
  assign br_offset  = r_off;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: a reference model pushes expected ID/EX contents,
// a negedge monitor compares and pops on acceptance. Follows ID_LONG_IMM_EN like the DUT.
module tb_id_stage_pipe;
  localparam int WL = 16;
  localparam int AL = 4;
  localparam int CL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, hazard = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [15:0]   instruction = '0;
  logic [WL-1:0] reg1 = '0, reg2 = '0;
  logic          in_ready, out_valid;
  logic [AL-1:0] src1, src2_reg_file, dest;
  logic [WL-1:0] val1, val2, br_offset;
  logic [CL-1:0] exe_cmd;
  logic          mem_r_en, mem_w_en, wb_en, is_imm, br_taken, jump_en;

  always #5 clk = ~clk;

  id_stage_pipe #(.WORD_LEN(WL), .REG_FILE_ADDR_LEN(AL), .EXE_CMD_LEN(CL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .src1(src1), .src2_reg_file(src2_reg_file),
    .reg1(reg1), .reg2(reg2), .hazard_detected_in(hazard), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .val1(val1), .val2(val2), .dest(dest),
    .EXE_CMD(exe_cmd), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en), .WB_EN(wb_en),
    .is_imm(is_imm), .brTaken(br_taken), .jumpEnable(jump_en), .br_offset(br_offset)
  );

  typedef struct packed {
    logic [WL-1:0] val1, val2, off;
    logic [AL-1:0] dest;
    logic [CL-1:0] cmd;
    logic          mr, mw, wb, imm, br, jmp, chk_off;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic          exp_in_ready = 1'b0;
  logic          exp_zero = 1'b0;
  logic          pending = 1'b0;
  logic [AL-1:0] pend_dest = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference decode straight from the opcode table.
  function automatic exp_t decode(input logic [15:0] ins, input logic [WL-1:0] a, b);
    exp_t          e;
    logic [WL-1:0] simm, zimm;
    simm = {{(WL-8){ins[7]}}, ins[7:0]};
    zimm = {{(WL-8){1'b0}}, ins[7:0]};
    e = '0;
    e.val1 = a; e.val2 = b; e.dest = ins[11:8]; e.off = simm; e.chk_off = 1'b1;
    case (ins[15:12])
      4'h1: begin e.cmd = 1; e.wb = 1; end
      4'h2: begin e.cmd = 2; e.wb = 1; end
      4'h3: begin e.cmd = 3; e.wb = 1; end
      4'h4: begin e.cmd = 4; e.wb = 1; end
      4'h5: begin e.cmd = 5; e.wb = 1; end
      4'h6: begin e.cmd = 6; e.wb = 1; e.imm = 1; e.val2 = zimm; end
      4'h7: begin e.cmd = 1; e.wb = 1; e.imm = 1; e.val2 = simm; end
      4'h8: begin e.cmd = 1; e.wb = 1; e.mr = 1; e.imm = 1; e.val2 = simm; end
      4'h9: begin e.cmd = 1; e.mw = 1; e.imm = 1; e.val2 = simm; end
      4'hA: e.br = (a == b);
      4'hB: e.br = (a != b);
      4'hC: e.jmp = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t ext_word(input logic [15:0] ins, input logic [AL-1:0] d);
    exp_t e;
    e = '0;
    e.val2 = {{(WL-16){1'b0}}, ins}; e.dest = d; e.cmd = 1; e.wb = 1; e.imm = 1;
    return e;
  endfunction

  // One clock: drive inputs after posedge, then advance the model for the coming edge.
  task automatic step(input logic v, input logic [15:0] ins, input logic [WL-1:0] a, b,
                      input logic hz, fl, ordy, rs);
    @(posedge clk); #1;
    in_valid = v; instruction = ins; reg1 = a; reg2 = b;
    hazard = hz; flush = fl; out_ready = ordy; rst = rs;
    exp_in_ready = rs && !hz && !fl && (q.size() == 0 || ordy);
    @(negedge clk); #1;
    if (!rs) begin
      q.delete(); pending = 0; exp_zero = 1;
    end else if (fl) begin
      q.delete(); pending = 0;
    end else if (v && exp_in_ready) begin
`ifdef ID_LONG_IMM_EN
      if (pending) begin
        q.push_back(ext_word(ins, pend_dest)); pending = 0; exp_zero = 0;
      end else if (ins[15:12] == 4'hD) begin
        pending = 1; pend_dest = ins[11:8];
      end else begin
        q.push_back(decode(ins, a, b)); exp_zero = 0;
      end
`else
      q.push_back(decode(ins, a, b)); exp_zero = 0;
`endif
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] op;
    op = instruction[15:12];
    check("in_ready", 64'(in_ready), 64'(exp_in_ready));
    check("src1", 64'(src1), 64'(instruction[11:8]));
    check("src2_reg_file", 64'(src2_reg_file),
          64'((op == 4'h9 || op == 4'hA || op == 4'hB) ? instruction[11:8] : instruction[7:4]));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (exp_zero)
      check("reset_zero", 64'({val1, val2, dest, exe_cmd, mem_r_en, mem_w_en, wb_en, is_imm,
                               br_taken, jump_en, br_offset} != '0), 64'(0));
    if (out_valid && q.size() > 0) begin
      check("val1", 64'(val1), 64'(q[0].val1));
      check("val2", 64'(val2), 64'(q[0].val2));
      check("dest", 64'(dest), 64'(q[0].dest));
      check("EXE_CMD", 64'(exe_cmd), 64'(q[0].cmd));
      check("MEM_R_EN", 64'(mem_r_en), 64'(q[0].mr));
      check("MEM_W_EN", 64'(mem_w_en), 64'(q[0].mw));
      check("WB_EN", 64'(wb_en), 64'(q[0].wb));
      check("is_imm", 64'(is_imm), 64'(q[0].imm));
      check("brTaken", 64'(br_taken), 64'(q[0].br));
      check("jumpEnable", 64'(jump_en), 64'(q[0].jmp));
      if (q[0].chk_off) check("br_offset", 64'(br_offset), 64'(q[0].off));
      if (out_ready) void'(q.pop_front());
    end
  end

  initial begin
    logic [WL-1:0] a, b;
    // Reset held two cycles, then released with EX ready.
    step(0, 16'h0, 0, 0, 0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0, 0, 1, 1);
    // ADDI r3, imm8=0xFE.
    step(1, 16'h73FE, 16'd5, 16'd0, 0, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0, 0, 1, 1);
    // BNE equal then unequal operands.
    step(1, 16'hB120, 16'd7, 16'd7, 0, 0, 1, 1);
    step(1, 16'hB120, 16'd7, 16'd8, 0, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0, 0, 1, 1);
    // LIMM r2 followed by its immediate word.
    step(1, 16'hD200, 16'h11, 16'h22, 0, 0, 1, 1);
    step(1, 16'hBEEF, 16'h33, 16'h44, 0, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0, 0, 1, 1);
    // Backpressure: valid output held for three cycles while new words wait.
    step(1, 16'h2345, 16'h1234, 16'h0F0F, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 16'h3456, 16'hAAAA, 16'h5555, 0, 0, 0, 1);
    // Hazard with EX ready drains to a bubble.
    step(1, 16'h3456, 16'hAAAA, 16'h5555, 1, 0, 1, 1);
    step(1, 16'h3456, 16'hAAAA, 16'h5555, 1, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0, 0, 1, 1);
    // LIMM, flush while a word is offered, then a plain ADD.
    step(1, 16'hD500, 0, 0, 0, 0, 1, 1);
    step(1, 16'h1234, 16'h9, 16'h6, 0, 1, 1, 1);
    step(1, 16'h1120, 16'h9, 16'h6, 0, 0, 1, 1);
    // Flush together with EX consuming the current output.
    step(1, 16'h5670, 16'hF0F0, 16'h0FF0, 0, 0, 0, 1);
    step(1, 16'h6781, 16'h1, 16'h2, 0, 1, 1, 1);
    step(0, 16'h0, 0, 0, 0, 0, 1, 1);
    // Reset while LIMM is pending; the next word must decode normally.
    step(1, 16'hD700, 0, 0, 0, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0, 0, 1, 0);
    step(1, 16'hC0F0, 16'h3, 16'h3, 0, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0, 0, 1, 1);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      a = ($urandom_range(0, 1) == 1) ? WL'($urandom_range(0, 3)) : WL'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a : WL'($urandom);
      step($urandom_range(0, 3) != 0, 16'($urandom), a, b,
           $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
    end
    for (int i = 0; i < 4; i++) step(0, 16'h0, 0, 0, 0, 0, 1, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
